// File: rtl/adc_pkg.sv
// Shared state encoding, default phase timing and conversion-length helper
// for the ADC sequencer.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SAMP   = 3'd2,
        ST_COMP   = 3'd3,
        ST_UPDATE = 3'd4
    } adc_state_e;

    localparam int DEF_MADC   = 17;
    localparam int DEF_T_INIT = 1;
    localparam int DEF_T_SAMP = 4;
    localparam int DEF_T_COMP = 1;
    localparam int DEF_T_UPD  = 1;

    // Cycles from the accepted start edge to the edge that completes the word.
    function automatic int conv_cycles(input int madc, input int t_init, input int t_samp,
                                       input int t_comp, input int t_upd);
        return t_init + t_samp + madc * t_comp + (madc - 1) * t_upd;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// Loadable phase down-counter; counts to zero and holds there, with a
// registered zero flag.
module adc_seq_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nx_s;
    logic         zero_r;

    // Next count: load takes priority, otherwise decrement until zero.
    always_comb begin
        cnt_nx_s = cnt_r;
        if (load) begin
            cnt_nx_s = load_val;
        end else if (cnt_r != {W{1'b0}}) begin
            cnt_nx_s = cnt_r - W'(1'b1);
        end else begin
            cnt_nx_s = cnt_r;
        end
    end

    // Counter and zero flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {W{1'b0}};
            zero_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_nx_s;
            zero_r <= (cnt_nx_s == {W{1'b0}});
        end
    end

    assign zero = zero_r;

endmodule

// File: rtl/adc_sequencer.sv
// SAR ADC sequencer: drives the init/sample/compare/update phases, collects
// Madc comparator decisions MSB-first and hands the word out over valid/ready.
module adc_sequencer
    import adc_pkg::*;
#(
    parameter int Madc   = DEF_MADC,
    parameter int T_INIT = DEF_T_INIT,
    parameter int T_SAMP = DEF_T_SAMP,
    parameter int T_COMP = DEF_T_COMP,
    parameter int T_UPD  = DEF_T_UPD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cont,
    output logic            busy,
    output logic            seq_init,
    output logic            seq_samp,
    output logic            seq_comp,
    output logic            seq_update,
    input  logic            comp_out,
    output logic [Madc-1:0] result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            overrun
);

    localparam int T_MAX = max4(T_INIT, T_SAMP, T_COMP, T_UPD);
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int IDX_W = $clog2(Madc);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(Madc - 1);

    if (Madc < 2 || T_INIT < 1 || T_SAMP < 1 || T_COMP < 1 || T_UPD < 1) begin : g_param_check
        $error("adc_sequencer: Madc must be >= 2 and every phase time >= 1");
    end

    adc_state_e        state_r, state_nx_s;
    logic              tmr_load_s, tmr_zero_s;
    logic [TW-1:0]     tmr_val_s;
    logic [IDX_W-1:0]  idx_r;
    logic [Madc-1:1]   shift_r;
    logic [Madc-1:0]   result_r, word_s;
    logic              result_valid_r, overrun_r, busy_r;
    logic              seq_init_r, seq_samp_r, seq_comp_r, seq_update_r;
    logic              seq_init_nx_s, seq_samp_nx_s, seq_comp_nx_s, seq_update_nx_s, busy_nx_s;
    logic              cmp_done_s, eoc_s, accept_s;

    adc_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    assign cmp_done_s = (state_r == ST_COMP) && tmr_zero_s;
    assign eoc_s      = cmp_done_s && (idx_r == {IDX_W{1'b0}});
    assign accept_s   = !result_valid_r || result_ready;
    assign word_s     = {shift_r, comp_out};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; every phase is left on the edge where the timer reads zero.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:   state_nx_s = start ? ST_INIT : ST_IDLE;
            ST_INIT:   state_nx_s = tmr_zero_s ? ST_SAMP : ST_INIT;
            ST_SAMP:   state_nx_s = tmr_zero_s ? ST_COMP : ST_SAMP;
            ST_COMP: begin
                if (!tmr_zero_s) begin
                    state_nx_s = ST_COMP;
                end else if (idx_r != {IDX_W{1'b0}}) begin
                    state_nx_s = ST_UPDATE;
                end else begin
                    state_nx_s = cont ? ST_INIT : ST_IDLE;
                end
            end
            ST_UPDATE: state_nx_s = tmr_zero_s ? ST_COMP : ST_UPDATE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Timer reload on every state change, with the entered phase length minus one.
    always_comb begin
        tmr_load_s = (state_nx_s != state_r);
        case (state_nx_s)
            ST_INIT:   tmr_val_s = TW'(T_INIT - 1);
            ST_SAMP:   tmr_val_s = TW'(T_SAMP - 1);
            ST_COMP:   tmr_val_s = TW'(T_COMP - 1);
            ST_UPDATE: tmr_val_s = TW'(T_UPD - 1);
            default:   tmr_val_s = {TW{1'b0}};
        endcase
    end

    // Output decode of the next state, so the phase flops track the state register exactly.
    always_comb begin
        seq_init_nx_s   = (state_nx_s == ST_INIT);
        seq_samp_nx_s   = (state_nx_s == ST_SAMP);
        seq_comp_nx_s   = (state_nx_s == ST_COMP);
        seq_update_nx_s = (state_nx_s == ST_UPDATE);
        busy_nx_s       = (state_nx_s != ST_IDLE);
    end

    // Phase and busy output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_init_r   <= 1'b0;
            seq_samp_r   <= 1'b0;
            seq_comp_r   <= 1'b0;
            seq_update_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            seq_init_r   <= seq_init_nx_s;
            seq_samp_r   <= seq_samp_nx_s;
            seq_comp_r   <= seq_comp_nx_s;
            seq_update_r <= seq_update_nx_s;
            busy_r       <= busy_nx_s;
        end
    end

    // Bit index and decision capture; bit 0 goes straight into the result word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= {IDX_W{1'b0}};
            shift_r <= {(Madc-1){1'b0}};
        end else if ((state_r == ST_SAMP) && tmr_zero_s) begin
            idx_r <= IDX_TOP;
        end else if (cmp_done_s && (idx_r != {IDX_W{1'b0}})) begin
            shift_r[idx_r] <= comp_out;
            idx_r          <= idx_r - IDX_W'(1'b1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Output word register with valid/ready handshake; a word finishing while blocked is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r       <= {Madc{1'b0}};
            result_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            overrun_r <= eoc_s && !accept_s;
            if (eoc_s && accept_s) begin
                result_r       <= word_s;
                result_valid_r <= 1'b1;
            end else if (result_valid_r && result_ready) begin
                result_valid_r <= 1'b0;
            end else begin
                result_valid_r <= result_valid_r;
            end
        end
    end

    assign busy         = busy_r;
    assign seq_init     = seq_init_r;
    assign seq_samp     = seq_samp_r;
    assign seq_comp     = seq_comp_r;
    assign seq_update   = seq_update_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_adc_sequencer.sv
// Scoreboard bench for adc_sequencer: expected words and their arrival cycles
// come from the conversion timing arithmetic, checked by a separate monitor.
module tb_adc_sequencer;

    localparam int M  = 17, TI  = 1, TS  = 4, TC  = 1, TU  = 1;
    localparam int N  = TI + TS + M * TC + (M - 1) * TU;
    localparam int M2 = 8,  TI2 = 1, TS2 = 7, TC2 = 2, TU2 = 3;
    localparam int N2 = TI2 + TS2 + M2 * TC2 + (M2 - 1) * TU2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, cont = 1'b0, comp_out = 1'b0, result_ready = 1'b0;
    logic busy, seq_init, seq_samp, seq_comp, seq_update, result_valid, overrun;
    logic [M-1:0] result;

    logic start2 = 1'b0, comp_out2 = 1'b0;
    logic busy2, seq_init2, seq_samp2, seq_comp2, seq_update2, result_valid2, overrun2;
    logic [M2-1:0] result2;

    typedef struct { logic [M-1:0] word; int at; } exp_t;
    exp_t exp_q[$];
    int   ovr_q[$];
    bit   sched[int];
    bit   sched2[int];

    int cyc = 0, checks = 0, passes = 0;
    int n_init = 0, n_samp = 0, n_comp = 0, n_upd = 0, r_comp = 0, r_upd = 0;
    logic prev_valid = 1'b0, prev_xfer = 1'b0, prev_comp = 1'b0, prev_upd = 1'b0;
    exp_t e_m;
    int   ovr_exp;

    adc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .busy(busy),
        .seq_init(seq_init), .seq_samp(seq_samp), .seq_comp(seq_comp), .seq_update(seq_update),
        .comp_out(comp_out), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .overrun(overrun)
    );

    adc_sequencer #(.Madc(M2), .T_INIT(TI2), .T_SAMP(TS2), .T_COMP(TC2), .T_UPD(TU2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .cont(1'b0), .busy(busy2),
        .seq_init(seq_init2), .seq_samp(seq_samp2), .seq_comp(seq_comp2), .seq_update(seq_update2),
        .comp_out(comp_out2), .result(result2), .result_valid(result_valid2),
        .result_ready(1'b1), .overrun(overrun2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // The decision is valid only in the cycle ending on its sampling edge; its neighbours carry the complement.
    always @(posedge clk) begin
        #1;
        if (sched.exists(cyc + 1))      comp_out = sched[cyc + 1];
        else if (sched.exists(cyc + 2)) comp_out = ~sched[cyc + 2];
        else if (sched.exists(cyc))     comp_out = ~sched[cyc];
        else                            comp_out = 1'($urandom);
        if (sched2.exists(cyc + 1))      comp_out2 = sched2[cyc + 1];
        else if (sched2.exists(cyc + 2)) comp_out2 = ~sched2[cyc + 2];
        else if (sched2.exists(cyc))     comp_out2 = ~sched2[cyc];
        else                             comp_out2 = 1'($urandom);
    end

    // Monitor: pops the scoreboard whenever a new word is presented or overrun pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0; prev_xfer = 1'b0; prev_comp = 1'b0; prev_upd = 1'b0;
        end else begin
            if (result_valid && (!prev_valid || prev_xfer)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: actual %0h required none (cycle %0d)", result, cyc);
                end else begin
                    e_m = exp_q.pop_front();
                    check("word", 32'(result), 32'(e_m.word));
                    check("word_cycle", cyc, e_m.at);
                end
            end
            if (overrun) begin
                if (ovr_q.size() == 0) begin
                    checks++;
                    $display("FAIL overrun_unexpected: actual 1 required 0 (cycle %0d)", cyc);
                end else begin
                    ovr_exp = ovr_q.pop_front();
                    check("overrun_cycle", cyc, ovr_exp);
                end
            end
            check("phase_exclusive", 32'($countones({seq_init, seq_samp, seq_comp, seq_update}) <= 1), 1);
            check("busy_vs_phase", 32'(busy), 32'(seq_init | seq_samp | seq_comp | seq_update));
            n_init += int'(seq_init);
            n_samp += int'(seq_samp);
            n_comp += int'(seq_comp);
            n_upd  += int'(seq_update);
            r_comp += int'(seq_comp && !prev_comp);
            r_upd  += int'(seq_update && !prev_upd);
            prev_comp  = seq_comp;
            prev_upd   = seq_update;
            prev_valid = result_valid;
            prev_xfer  = result_valid && result_ready;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic launch(input logic [M-1:0] w, input bit expect_out, output int e0);
        @(posedge clk); #1;
        e0 = cyc + 1;
        for (int k = 0; k < M; k++) sched[e0 + TI + TS + (k + 1) * TC + k * TU] = w[M-1-k];
        if (expect_out) exp_q.push_back('{w, e0 + N});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, 32'({busy, seq_init, seq_samp, seq_comp, seq_update, result_valid, overrun}), 0);
        check({tag, "_result"}, 32'(result), 0);
    endtask

    initial begin
        int e0, ea, eb;
        logic [M-1:0] w, wa, wb;
        logic [M2-1:0] w2;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        @(negedge clk); rst_n = 1'b1;
        result_ready = 1'b1;

        // Non-default timing instance: N2 = 45, decision on the second COMP cycle.
        @(posedge clk); #1;
        e0 = cyc + 1;
        w2 = 8'($urandom);
        for (int k = 0; k < M2; k++) sched2[e0 + TI2 + TS2 + (k + 1) * TC2 + k * TU2] = w2[M2-1-k];
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        wait_until(e0 + N2 - 1);
        check("n2_valid_early", 32'(result_valid2), 0);
        wait_until(e0 + N2);
        check("n2_valid", 32'(result_valid2), 1);
        check("n2_word", 32'(result2), 32'(w2));
        check("n2_no_overrun", 32'(overrun2), 0);

        // Single conversion with alternating decisions and phase accounting.
        n_init = 0; n_samp = 0; n_comp = 0; n_upd = 0; r_comp = 0; r_upd = 0;
        launch(17'h15555, 1'b1, e0);
        wait_until(e0 + N);
        check("alt_result", 32'(result), 32'h15555);
        check("init_cycles", n_init, TI);
        check("samp_cycles", n_samp, TS);
        check("comp_cycles", n_comp, M * TC);
        check("upd_cycles", n_upd, (M - 1) * TU);
        check("comp_phases", r_comp, M);
        check("upd_phases", r_upd, M - 1);
        wait_until(e0 + N + 3);

        // Continuous mode: three back-to-back words, a start while busy is ignored.
        cont = 1'b1;
        launch(17'($urandom), 1'b1, e0);
        for (int j = 1; j < 3; j++) begin
            w = 17'($urandom);
            for (int k = 0; k < M; k++) sched[e0 + j * N + TI + TS + (k + 1) * TC + k * TU] = w[M-1-k];
            exp_q.push_back('{w, e0 + (j + 1) * N});
        end
        wait_until(e0 + 10);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_until(e0 + N);
        check("cont_init_adjacent", 32'(seq_init), 1);
        check("cont_busy", 32'(busy), 1);
        wait_until(e0 + 2 * N + 5);
        cont = 1'b0;
        wait_until(e0 + 3 * N);
        check("cont_stop_idle", 32'(busy), 0);
        wait_until(e0 + 3 * N + 3);

        // Overrun: consumer stalled across two conversions.
        result_ready = 1'b0;
        wa = 17'($urandom);
        launch(wa, 1'b1, ea);
        wait_until(ea + N + 2);
        launch(17'($urandom), 1'b0, eb);
        ovr_q.push_back(eb + N);
        wait_until(eb + N);
        check("ovr_hold_valid", 32'(result_valid), 1);
        check("ovr_hold_word", 32'(result), 32'(wa));
        result_ready = 1'b1;
        wait_until(eb + N + 2);
        check("ovr_drained", 32'(result_valid), 0);

        // Ready arrives on the same edge a new word completes.
        result_ready = 1'b0;
        launch(17'($urandom), 1'b1, ea);
        wait_until(ea + N + 2);
        wb = 17'($urandom);
        launch(wb, 1'b1, eb);
        wait_until(eb + N - 1);
        result_ready = 1'b1;
        wait_until(eb + N);
        check("same_edge_valid", 32'(result_valid), 1);
        check("same_edge_word", 32'(result), 32'(wb));
        wait_until(eb + N + 2);

        // Asynchronous reset mid-SAMP and mid-COMP.
        launch(17'($urandom), 1'b0, e0);
        wait_until(e0 + TI + 2);
        check("in_samp", 32'(seq_samp), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_samp");
        sched.delete();
        @(negedge clk); rst_n = 1'b1;
        launch(17'($urandom), 1'b0, e0);
        wait_until(e0 + TI + TS + 2);
        check("in_comp", 32'(seq_comp), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_comp");
        sched.delete();
        @(negedge clk); rst_n = 1'b1;
        launch(17'($urandom), 1'b1, e0);
        wait_until(e0 + 12);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_until(e0 + N);
        check("post_reset_valid", 32'(result_valid), 1);
        wait_until(e0 + N + 2);

        // Randomised single conversions with random gaps and ignored starts.
        for (int it = 0; it < 6; it++) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            launch(17'($urandom), 1'b1, e0);
            if ($urandom_range(0, 1) == 1) begin
                wait_until(e0 + int'($urandom_range(3, 30)));
                start = 1'b1; @(posedge clk); #1; start = 1'b0;
            end
            wait_until(e0 + N);
        end
        wait_until(cyc + 4);

        check("words_pending", exp_q.size(), 0);
        check("overruns_pending", ovr_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
